cycle_sequencer: RTL and testbench

Multi-cycle control sequencer for the 16-bit processor datapath. Steps each instruction through fetch, decode, execute, memory and writeback. Drives the register and memory enables, the PC update path and the writeback mux selects. Handshakes with RAM through a req/ack pair and retires one instruction at a time, with a retire counter and fault reporting.

---
 rtl/cycle_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_cycle_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer with req/ack RAM handshake.
// Optional stall counter output enabled by defining SEQ_STALL_COUNT_EN.
module cycle_sequencer #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [3:0]  OP_LOAD  = 4'hA,
  parameter logic [3:0]  OP_STORE = 4'hB,
  parameter logic [3:0]  OP_JUMP  = 4'hC,
  parameter logic [3:0]  OP_HALT  = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic [3:0]  opcode,
  input  logic        flag_en_in,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_rw,
  output logic        addr_sel,
  output logic        ir_en,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        flag_we,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count
`ifdef SEQ_STALL_COUNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALTED
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        fault_q, fault_d;
  logic        wbsel_q, wbsel_d;
  logic [15:0] instr_count_q;
  logic        retire;
  state_t      boundary;

  // Every transition into FETCH is an instruction boundary where halt_req is honoured.
  assign boundary = halt_req ? S_HALTED : S_FETCH;

  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;
    fault_d  = fault_q;
    wbsel_d  = wbsel_q;
    retire   = 1'b0;
    mem_req  = 1'b0;
    mem_rw   = 1'b0;
    addr_sel = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = 1'b0;
    flag_we  = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = boundary;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_q == TO_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALTED;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          retire  = 1'b1;
          state_d = S_HALTED;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        flag_we = flag_en_in;
        if (opcode == OP_JUMP) begin
          pc_en   = 1'b1;
          pc_sel  = 1'b1;
          retire  = 1'b1;
          state_d = boundary;
        end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_d = S_MEMORY;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_rw   = (opcode == OP_STORE);
        if (mem_ack) begin
          if (opcode == OP_STORE) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = boundary;
          end else begin
            wbsel_d = 1'b1;
            state_d = S_WRITEBACK;
          end
        end else if (tmo_q == TO_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALTED;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WRITEBACK: begin
        reg_we  = 1'b1;
        wb_sel  = wbsel_q;
        pc_en   = 1'b1;
        retire  = 1'b1;
        wbsel_d = 1'b0;
        state_d = boundary;
      end
      S_HALTED: begin
        if (start && !halt_req) begin
          fault_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tmo_q         <= '0;
      fault_q       <= 1'b0;
      wbsel_q       <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      fault_q       <= fault_d;
      wbsel_q       <= wbsel_d;
      instr_count_q <= instr_count_q + {15'd0, retire};
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted      = (state_q == S_HALTED);
  assign fault       = fault_q;
  assign instr_count = instr_count_q;

`ifdef SEQ_STALL_COUNT_EN
  logic [15:0] stall_q;
  logic        start_take;

  assign start_take = start && (state_q == S_IDLE || state_q == S_HALTED);

  always_ff @(posedge clk) begin
    if (reset || start_take) begin
      stall_q <= '0;
    end else if (mem_req && !mem_ack && stall_q != '1) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed self-checking bench for cycle_sequencer: ALU/LOAD/STORE/JUMP flows, timeout fault,
// halt handling, retire-counter wrap and mid-access reset.
module tb_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, halt_req, flag_en_in, mem_ack;
  logic [3:0]  opcode;
  logic        mem_req, mem_rw, addr_sel, ir_en, pc_en, pc_sel, flag_we, reg_we, wb_sel;
  logic        busy, halted, fault;
  logic [15:0] instr_count;
`ifdef SEQ_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  // {mem_req,mem_rw,addr_sel,ir_en, pc_en,pc_sel,flag_we,reg_we, wb_sel,busy,halted,fault}
  localparam logic [11:0] E_IDLE    = 12'b0000_0000_0000;
  localparam logic [11:0] E_F_ACK   = 12'b1001_0000_0100;
  localparam logic [11:0] E_F_WAIT  = 12'b1000_0000_0100;
  localparam logic [11:0] E_DEC     = 12'b0000_0000_0100;
  localparam logic [11:0] E_EX_FLAG = 12'b0000_0010_0100;
  localparam logic [11:0] E_EX_JMP  = 12'b0000_1100_0100;
  localparam logic [11:0] E_MEM_LD  = 12'b1010_0000_0100;
  localparam logic [11:0] E_MEM_ST  = 12'b1110_1000_0100;
  localparam logic [11:0] E_WB_ALU  = 12'b0000_1001_0100;
  localparam logic [11:0] E_WB_LD   = 12'b0000_1001_1100;
  localparam logic [11:0] E_HALT    = 12'b0000_0000_0010;
  localparam logic [11:0] E_HALT_F  = 12'b0000_0000_0011;

  logic [11:0] obs;
  assign obs = {mem_req, mem_rw, addr_sel, ir_en, pc_en, pc_sel, flag_we, reg_we,
                wb_sel, busy, halted, fault};

  cycle_sequencer #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .opcode(opcode),
    .flag_en_in(flag_en_in), .mem_ack(mem_ack), .mem_req(mem_req), .mem_rw(mem_rw),
    .addr_sel(addr_sel), .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .flag_we(flag_we),
    .reg_we(reg_we), .wb_sel(wb_sel), .busy(busy), .halted(halted), .fault(fault),
    .instr_count(instr_count)
`ifdef SEQ_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [11:0] exp);
    #1;
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: outputs got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    #1;
    tests++;
    assert (instr_count === exp) else begin
      fails++;
      $error("FAIL %s: instr_count got %h expected %h", tag, instr_count, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; flag_en_in = 1'b0;
    mem_ack = 1'b0; opcode = 4'h0;
    step(); step();
    chk_out("reset_outs", E_IDLE);
    chk_cnt("reset_cnt", 16'h0000);
    reset = 1'b0;

    // ALU op 4'h1, zero-wait memory, flag update requested
    start = 1'b1; opcode = 4'h1; flag_en_in = 1'b1; mem_ack = 1'b1;
    chk_out("idle_ack_ignored", E_IDLE);
    step(); start = 1'b0;
    chk_out("alu_fetch", E_F_ACK);
    step(); chk_out("alu_decode", E_DEC);
    step(); chk_out("alu_exec_flag", E_EX_FLAG);
    step(); chk_out("alu_wb", E_WB_ALU);
    step(); chk_cnt("alu_retire", 16'h0001);

    // LOAD with ack delayed 3 cycles in MEMORY
    opcode = 4'hA; flag_en_in = 1'b0;
    chk_out("ld_fetch", E_F_ACK);
    step(); chk_out("ld_decode", E_DEC);
    step(); mem_ack = 1'b0;
    chk_out("ld_exec", E_DEC);
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("ld_mem_wait", E_MEM_LD);
    end
    step(); mem_ack = 1'b1;
    chk_out("ld_mem_ack", E_MEM_LD);
    step(); chk_out("ld_wb", E_WB_LD);
    step(); chk_cnt("ld_retire", 16'h0002);

    // STORE then JUMP
    opcode = 4'hB;
    step(); chk_out("st_decode", E_DEC);
    step(); chk_out("st_exec", E_DEC);
    step(); chk_out("st_mem_ack", E_MEM_ST);
    step(); chk_cnt("st_retire", 16'h0003);
    opcode = 4'hC; flag_en_in = 1'b0;
    chk_out("jmp_fetch", E_F_ACK);
    step(); chk_out("jmp_decode", E_DEC);
    step(); chk_out("jmp_exec", E_EX_JMP);
    step(); chk_cnt("jmp_retire", 16'h0004);

    // FETCH timeout: 15 cycles without ack
    mem_ack = 1'b0;
    chk_out("to_fetch_1", E_F_WAIT);
    for (int i = 0; i < 14; i++) step();
    chk_out("to_fetch_15", E_F_WAIT);
    step(); chk_out("to_halted_fault", E_HALT_F);
    chk_cnt("to_no_retire", 16'h0004);
    start = 1'b1;
    chk_out("to_start_pending", E_HALT_F);
    step(); start = 1'b0;
    chk_out("to_restart_fetch", E_F_WAIT);

    // Ack on the exact expiry cycle wins
    for (int i = 0; i < 14; i++) step();
    mem_ack = 1'b1; opcode = 4'h1;
    chk_out("exp_ack_fetch", E_F_ACK);
    step(); chk_out("exp_ack_decode", E_DEC);

    // halt_req during EXECUTE of an ALU op
    step(); halt_req = 1'b1;
    chk_out("hr_exec", E_DEC);
    step(); chk_out("hr_wb", E_WB_ALU);
    step(); chk_out("hr_halted", E_HALT);
    chk_cnt("hr_retire", 16'h0005);

    // start with halt_req still high stays HALTED
    start = 1'b1;
    step(); chk_out("hr_start_blocked", E_HALT);
    halt_req = 1'b0; opcode = 4'hF;
    step(); start = 1'b0;
    chk_out("halt_op_fetch", E_F_ACK);
    step(); chk_out("halt_op_decode", E_DEC);
    step(); chk_out("halt_op_halted", E_HALT);
    chk_cnt("halt_op_retire", 16'h0006);

    // Counter wrap: preload near the top, then two OP_HALT retires
    force dut.instr_count_q = 16'hFFFE;
    step();
    release dut.instr_count_q;
    chk_cnt("wrap_preload", 16'hFFFE);
    start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    chk_cnt("wrap_ffff", 16'hFFFF);
    start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    chk_cnt("wrap_zero", 16'h0000);
    chk_out("wrap_halted", E_HALT);

    // Reset asserted while in MEMORY
    start = 1'b1; opcode = 4'hA;
    step(); start = 1'b0;
    step(); mem_ack = 1'b0;
    step();
    step(); chk_out("rst_mem_state", E_MEM_LD);
    reset = 1'b1; mem_ack = 1'b1;
    step(); chk_out("rst_mem_idle", E_IDLE);
    chk_cnt("rst_mem_cnt", 16'h0000);
    reset = 1'b0; mem_ack = 1'b0;
    step(); chk_out("rst_stays_idle", E_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
